// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
// REGFILE_BYPASS_EN selects same-cycle write-to-read forwarding in regfile_mp_sb.
package regfile_pkg;

  localparam int REG_ZERO = 0;

  localparam int PKG_AW = 5;
  localparam int PKG_DW = 32;

  typedef struct packed {
    logic [PKG_AW-1:0] id;
    logic [PKG_DW-1:0] data;
  } rf_rd_port_t;

  typedef struct packed {
    logic              en;
    logic [PKG_AW-1:0] id;
    logic [PKG_DW-1:0] data;
  } rf_wr_port_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Write scoreboard: one busy bit per register, set at issue, cleared at writeback.
// A same-cycle issue and writeback of one register leaves it busy for the new producer.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NWR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_rd,
  output logic              o_iss_ready,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_id,
  output logic [NREGS-1:0]  o_busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic             w_wr_hit_iss;
  logic             w_ready;
  logic             w_accept;

  always_comb begin
    w_clr        = '0;
    w_wr_hit_iss = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j] && (i_wr_id[j*AW +: AW] != AW'(REG_ZERO))) begin
        w_clr[i_wr_id[j*AW +: AW]] = 1'b1;
        if (i_wr_id[j*AW +: AW] == i_iss_rd) w_wr_hit_iss = 1'b1;
      end
    end
  end

  // A pending destination is only re-reserved when its writeback lands this cycle.
  assign w_ready  = rst || (i_iss_rd == AW'(REG_ZERO)) || !r_busy[i_iss_rd] || w_wr_hit_iss;
  assign w_accept = i_iss_valid && w_ready && (i_iss_rd != AW'(REG_ZERO));

  always_comb begin
    w_set = '0;
    if (w_accept) w_set[i_iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign o_iss_ready = w_ready;
  assign o_busy_vec  = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (NRD async reads, NWR sync writes, x0 hardwired to zero) with
// scoreboard hazard flags. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  localparam int AW    = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     i_rd_id,
  output logic [NRD*DWIDTH-1:0] o_rd_data,
  output logic [NRD-1:0]        o_rd_hazard,
  input  logic                  i_iss_valid,
  input  logic [AW-1:0]         i_iss_rd,
  output logic                  o_iss_ready,
  input  logic [NWR-1:0]        i_wr_en,
  input  logic [NWR*AW-1:0]     i_wr_id,
  input  logic [NWR*DWIDTH-1:0] i_wr_data,
  output logic [NREGS-1:0]      o_busy_vec
);

  logic [NREGS-1:0][DWIDTH-1:0] r_mem;
  logic [NWR-1:0][AW-1:0]       w_wr_id;
  logic [NWR-1:0][DWIDTH-1:0]   w_wr_data;
  logic [NREGS-1:0]             w_busy;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign w_wr_id[j]   = i_wr_id[j*AW +: AW];
    assign w_wr_data[j] = i_wr_data[j*DWIDTH +: DWIDTH];
  end

  regfile_sb #(
    .NREGS (NREGS),
    .AW    (AW),
    .NWR   (NWR)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_iss_valid (i_iss_valid),
    .i_iss_rd    (i_iss_rd),
    .o_iss_ready (o_iss_ready),
    .i_wr_en     (i_wr_en),
    .i_wr_id     (i_wr_id),
    .o_busy_vec  (w_busy)
  );

  assign o_busy_vec = w_busy;

  // Ports are visited in ascending order so the highest-index port wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && (w_wr_id[j] != AW'(REG_ZERO))) r_mem[w_wr_id[j]] <= w_wr_data[j];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     w_id;
    logic [DWIDTH-1:0] w_sel;
    logic              w_hit;

    assign w_id = i_rd_id[k*AW +: AW];

    always_comb begin
      w_sel = r_mem[w_id];
      w_hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && (w_wr_id[j] == w_id) && (w_id != AW'(REG_ZERO))) begin
          w_sel = w_wr_data[j];
          w_hit = 1'b1;
        end
      end
`endif
    end

    assign o_rd_data[k*DWIDTH +: DWIDTH] =
      (rst || (w_id == AW'(REG_ZERO))) ? '0 : w_sel;
    assign o_rd_hazard[k] = !rst && w_busy[w_id] && !w_hit;
  end

endmodule
